decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
- Upstream sequencer for the team's 3-to-8 enabled decoder: generates the 3-bit select and the active-high enable that scan eight multiplexed outputs (LED columns / 7-seg digits).
- Steps through the positions enabled in a mask, in either direction, with a programmable dwell time per position and a blanking gap between positions to prevent ghosting.
- Outputs are registered and connect directly to the decoder's select and enable inputs.

Parameters:
- PRESCALE, 4: enable-high dwell cycles per position; legal range >= 1.
- BLANK, 1: enable-low gap cycles between positions; legal range >= 0.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled in IDLE only, begins scanning.
- stop  input  1  level; aborts scanning; has priority over start.
- dir  input  1  0 = ascending index, 1 = descending; sampled at scan start and at each advance.
- mask  input  8  bit k = 1 means position k is scanned; sampled at scan start and at each advance.
- sel  output  3  position index to decoder select.
- en  output  1  decoder enable.
- busy  output  1  high in DWELL or BLANK.
- wrap  output  1  one-cycle pulse when an advance wraps past the end of the sequence.

Behaviour:
- Reset (rst high at edge): state IDLE, sel=0, en=0, busy=0, wrap=0, dwell/blank counter=0. Reset overrides every other input in any state.
- All outputs are registered: a state change sampled at edge t is visible from cycle t+1.
- States are IDLE, DWELL and BLANK. en=1 only in DWELL; busy=1 in DWELL and BLANK.
- IDLE:
  - stop=1: remain IDLE.
  - start=1 and mask!=0: go to DWELL and load sel with the first enabled position (lowest set bit if dir=0, highest if dir=1). Counter=0.
  - start=1 and mask==0: remain IDLE.
  - sel holds its last value while in IDLE.
- DWELL:
  - en stays high for exactly PRESCALE cycles.
  - On the last dwell cycle: if BLANK>0, go to BLANK; if BLANK==0, advance immediately to the next DWELL. In that case en stays high continuously and sel changes.
- BLANK: en=0 for exactly BLANK cycles, then advance.
- Advance:
  - Next position = next set bit of the current mask strictly after sel in direction dir, searching modulo 8.
  - If the search passes index 7 going up, or index 0 going down, wrap=1 for the cycle in which the new sel first appears.
  - If only one position is enabled, every advance reselects it and pulses wrap.
  - sel updates in the same cycle en rises for the new position; sel never changes while en=1 except when BLANK==0.
- Mask going to 0 at an advance: go to IDLE, en=0, sel held, wrap=0.
- stop=1 in DWELL or BLANK: next cycle IDLE, en=0, busy=0, sel held, counter cleared, no wrap pulse.
- start is ignored while busy.
- Changes to mask or dir between advances have no effect until the next advance.
- Counter width is sufficient for max(PRESCALE, BLANK), so there is no overflow.

Test Plan:
1. Reset, then start with mask=8'hFF, dir=0 (PRESCALE=4, BLANK=1) -> sel sequence 0,1,...,7,0. Each position has en=1 for 4 cycles then en=0 for 1 cycle (5-cycle period). wrap pulses once with sel=0 on the second pass.
2. mask=8'b1010_0100, dir=1 -> sel sequence 7,5,2,7. wrap pulses on the return to 7. Positions 0,1,3,4,6 are never selected.
3. BLANK=0 build, mask=8'h03, dir=0 -> en is continuously 1 while sel toggles 0,1,0 every 4 cycles. wrap pulses on each return to 0.
4. Assert stop during the 2nd dwell cycle of position 3 -> next cycle en=0, busy=0, sel=3. A subsequent start with dir=0 and mask=8'hFF restarts at sel=0.
5. Clear mask to 0 mid-dwell -> the current dwell completes, then at the advance the block enters IDLE with en=0. Start with mask=0 -> busy stays 0.
6. Assert rst mid-BLANK with start held high -> next cycle all outputs 0 and state IDLE. After rst is released, scanning resumes from the first enabled position.

Source files
------------

// File: rtl/decoder_scan_if.sv
// Bus between a scan controller and the agent that commands it.
// Commands are level-sensitive, so there is no valid/ready pairing. start is sampled only in IDLE,
// stop overrides start, and dir/mask are sampled at scan start and at each advance.
interface decoder_scan_if;
  logic       start;
  logic       stop;
  logic       dir;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       en;
  logic       busy;
  logic       wrap;
  logic [1:0] state_dbg;

  modport master (output start, stop, dir, mask,
                  input  sel, en, busy, wrap, state_dbg);
  modport slave  (input  start, stop, dir, mask,
                  output sel, en, busy, wrap, state_dbg);
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-to-8 enabled decoder: walks the enabled positions of a mask
// with a PRESCALE-cycle dwell (en high) and a BLANK-cycle gap (en low) between positions.
module decoder_scan_ctrl #(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1
) (
  input  logic           clk,
  input  logic           rst,
  decoder_scan_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1, S_BLANK = 2'd2} state_t;

  localparam int CMAX       = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CW         = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;
  localparam logic [CW-1:0] DWELL_END = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_LAST);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    sel_q;
  logic          en_q, busy_q, wrap_q;

  logic [2:0]    first_sel, next_sel;
  logic          next_wrap, do_adv;

  // Next set bit strictly after cur in direction d, modulo 8 (returns cur if it is the only one).
  function automatic logic [2:0] next_pos(input logic [7:0] m, input logic [2:0] cur,
                                          input logic d);
    logic [2:0] res;
    logic [2:0] cand;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = d ? (cur - 3'(i)) : (cur + 3'(i));
      if (!found && m[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    first_sel = next_pos(bus.mask, bus.dir ? 3'd0 : 3'd7, bus.dir);
    next_sel  = next_pos(bus.mask, sel_q, bus.dir);
    // Landing at or behind the current index means the search crossed the end.
    next_wrap = bus.dir ? (next_sel >= sel_q) : (next_sel <= sel_q);
    do_adv    = ((state == S_DWELL) && (cnt == DWELL_END) && (BLANK == 0)) ||
                ((state == S_BLANK) && (cnt == BLANK_END));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sel_q  <= 3'd0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (state != S_IDLE && bus.stop) begin
        state  <= S_IDLE;
        cnt    <= '0;
        en_q   <= 1'b0;
        busy_q <= 1'b0;
      end else if (do_adv) begin
        cnt <= '0;
        if (bus.mask == 8'd0) begin
          state  <= S_IDLE;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
        end else begin
          state  <= S_DWELL;
          sel_q  <= next_sel;
          en_q   <= 1'b1;
          wrap_q <= next_wrap;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (!bus.stop && bus.start && (bus.mask != 8'd0)) begin
              state  <= S_DWELL;
              cnt    <= '0;
              sel_q  <= first_sel;
              en_q   <= 1'b1;
              busy_q <= 1'b1;
            end
          end
          S_DWELL: begin
            if (cnt == DWELL_END) begin
              state <= S_BLANK;
              cnt   <= '0;
              en_q  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_BLANK: cnt <= cnt + 1'b1;
          default: begin
            state  <= S_IDLE;
            cnt    <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: a BLANK=1 and a BLANK=0 instance driven in lockstep,
// compared every cycle against a position/age reference model, plus directed checks.
module tb_decoder_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decoder_scan_if if0 ();
  decoder_scan_if if1 ();

  decoder_scan_ctrl #(.PRESCALE(4), .BLANK(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  decoder_scan_ctrl #(.PRESCALE(4), .BLANK(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       dir   = 1'b0;
  logic [7:0] mask  = 8'd0;

  assign if0.start = start;
  assign if0.stop  = stop;
  assign if0.dir   = dir;
  assign if0.mask  = mask;
  assign if1.start = start;
  assign if1.stop  = stop;
  assign if1.dir   = dir;
  assign if1.mask  = mask;

  int checks = 0;
  int errors = 0;
  int wraps0 = 0;
  int wraps1 = 0;
  int enlow1 = 0;
  logic [7:0] seen0 = 8'd0;

  // Reference: scanning or not, current position, and age within its (dwell + blank) period.
  typedef struct {
    bit active;
    int sel;
    int age;
    bit wrap;
  } mdl_t;

  mdl_t m0 = '{0, 0, 0, 0};
  mdl_t m1 = '{0, 0, 0, 0};

  function automatic mdl_t step(mdl_t m, int p, int b, bit r, bit st, bit sp, bit d,
                                logic [7:0] mk);
    mdl_t n;
    n = m;
    n.wrap = 0;
    if (r) begin
      n.active = 0; n.sel = 0; n.age = 0;
    end else if (!m.active) begin
      if (!sp && st && mk != 0) begin
        n.active = 1;
        n.age    = 0;
        if (d) begin
          for (int k = 0; k < 8; k++) if (mk[k]) n.sel = k;
        end else begin
          for (int k = 7; k >= 0; k--) if (mk[k]) n.sel = k;
        end
      end
    end else if (sp) begin
      n.active = 0; n.age = 0;
    end else if (m.age == p + b - 1) begin
      n.age = 0;
      if (mk == 0) n.active = 0;
      else begin
        for (int i = 1; i <= 8; i++) begin
          int raw;
          int idx;
          raw = d ? m.sel - i : m.sel + i;
          idx = (raw + 16) % 8;
          if (mk[idx]) begin
            n.sel  = idx;
            n.wrap = (raw < 0) || (raw > 7);
            break;
          end
        end
      end
    end else begin
      n.age = m.age + 1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = step(m0, 4, 1, rst, start, stop, dir, mask);
    m1 = step(m1, 4, 0, rst, start, stop, dir, mask);
    #1;
    check("sel0",  {5'd0, if0.sel},  8'(m0.sel));
    check("en0",   {7'd0, if0.en},   {7'd0, m0.active && m0.age < 4});
    check("busy0", {7'd0, if0.busy}, {7'd0, m0.active});
    check("wrap0", {7'd0, if0.wrap}, {7'd0, m0.wrap});
    check("sel1",  {5'd0, if1.sel},  8'(m1.sel));
    check("en1",   {7'd0, if1.en},   {7'd0, m1.active && m1.age < 4});
    check("busy1", {7'd0, if1.busy}, {7'd0, m1.active});
    check("wrap1", {7'd0, if1.wrap}, {7'd0, m1.wrap});
    if (if0.wrap === 1'b1) wraps0++;
    if (if1.wrap === 1'b1) wraps1++;
    if (if1.en !== 1'b1) enlow1++;
    if (if0.en === 1'b1) seen0[if0.sel] = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_scan(input logic [7:0] mk, input logic d);
    mask = mk; dir = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check("rst_sel",  {5'd0, if0.sel},  8'd0);
    check("rst_en",   {7'd0, if0.en},   8'd0);
    check("rst_busy", {7'd0, if0.busy}, 8'd0);
    check("rst_wrap", {7'd0, if0.wrap}, 8'd0);

    // Full mask ascending: 8 periods of 5 cycles, one wrap back to 0
    start_scan(8'hFF, 1'b0);
    check("t1_first", {5'd0, if0.sel}, 8'd0);
    wraps0 = 0;
    run(40);
    check("t1_wraps", 8'(wraps0), 8'd1);
    check("t1_sel_after_wrap", {5'd0, if0.sel}, 8'd0);
    halt();

    // Sparse mask descending: only 7, 5, 2 ever enabled
    seen0 = 8'd0;
    start_scan(8'b1010_0100, 1'b1);
    check("t2_first", {5'd0, if0.sel}, 8'd7);
    run(20);
    check("t2_seen", seen0 | {7'd0, 1'b0}, 8'hA4);
    halt();

    // Two positions, BLANK=0 instance keeps en high continuously
    start_scan(8'h03, 1'b0);
    enlow1 = 0;
    wraps1 = 0;
    run(16);
    check("t3_enlow", 8'(enlow1), 8'd0);
    check("t3_wraps", 8'(wraps1), 8'd2);
    halt();

    // Stop during 2nd dwell cycle of position 3, then restart from 0
    start_scan(8'hFF, 1'b0);
    run(16);
    check("t4_pre_sel", {5'd0, if0.sel}, 8'd3);
    halt();
    check("t4_en",   {7'd0, if0.en},   8'd0);
    check("t4_busy", {7'd0, if0.busy}, 8'd0);
    check("t4_sel",  {5'd0, if0.sel},  8'd3);
    start_scan(8'hFF, 1'b0);
    check("t4_restart", {5'd0, if0.sel}, 8'd0);

    // Mask cleared mid-dwell: dwell completes, then idle; start with empty mask stays idle
    run(1);
    mask = 8'd0;
    run(6);
    check("t5_busy", {7'd0, if0.busy}, 8'd0);
    check("t5_sel",  {5'd0, if0.sel},  8'd0);
    start = 1'b1;
    run(3);
    check("t5_empty_start", {7'd0, if0.busy}, 8'd0);
    start = 1'b0;

    // Reset mid-blank with start held, then resume from first enabled position
    start_scan(8'b0011_0000, 1'b0);
    run(4);
    check("t6_in_blank", {7'd0, if0.en}, 8'd0);
    rst = 1'b1; start = 1'b1;
    tick();
    check("t6_sel",  {5'd0, if0.sel},  8'd0);
    check("t6_busy", {7'd0, if0.busy}, 8'd0);
    rst = 1'b0;
    tick();
    check("t6_resume", {5'd0, if0.sel}, 8'd4);
    start = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      start = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) dir = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) mask = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
